// File: rtl/axis_lfsr_checker.sv
// axis_lfsr_checker
//
// AXI4-Stream sink that checks a 64-bit PRBS stream against a local copy of the
// generator LFSR and gathers bit-error statistics for software readout.
//
// The checker seeds its local LFSR from the first word it sees (HUNT). It then
// needs a run of matching words to trust the seed (SYNC). Once locked it
// free-runs the local LFSR and counts compared and mismatched words (LOCK). A
// run of consecutive mismatches drops it back to HUNT.
//
// Ports:
//   aclk           clock
//   areset         synchronous, active-high reset
//   clear          zeroes err_count and word_count; sync state is untouched
//   s_axis_tready  slave ready; registered, high from the first cycle after reset
//   s_axis_tdata   received PRBS word
//   s_axis_tvalid  slave valid
//   locked         checker is in LOCK
//   err_flag       one-cycle pulse per mismatched word seen in LOCK
//   err_count      mismatched words counted in LOCK (saturating)
//   word_count     words compared in LOCK (saturating)

module axis_lfsr_checker #(
  parameter int unsigned CNTR_WIDTH = 32,
  parameter int unsigned LOCK_COUNT = 16,
  parameter int unsigned LOSS_COUNT = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  clear,
  output logic                  s_axis_tready,
  input  logic [63:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  locked,
  output logic                  err_flag,
  output logic [CNTR_WIDTH-1:0] err_count,
  output logic [CNTR_WIDTH-1:0] word_count
);

  // Run counters only need to hold up to (threshold - 1): the threshold-th
  // event causes the state transition instead of being stored.
  localparam int unsigned GoodW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int unsigned BadW  = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT) : 1;

  localparam logic [GoodW-1:0]      GoodLast = GoodW'(LOCK_COUNT - 1);
  localparam logic [BadW-1:0]       BadLast  = BadW'(LOSS_COUNT - 1);
  localparam logic [CNTR_WIDTH-1:0] CntOne   = CNTR_WIDTH'(1);

  typedef enum logic [1:0] {
    StHunt,
    StSync,
    StLock
  } state_e;

  // Same step as the generator: shift left, feed back XNOR of bits 62 and 61.
  function automatic logic [63:0] lfsr_step(input logic [63:0] x);
    return {x[62:0], ~(x[62] ^ x[61])};
  endfunction

  state_e                state_q, state_d;
  logic [63:0]           pred_q, pred_d;
  logic [GoodW-1:0]      good_q, good_d;
  logic [BadW-1:0]       bad_q, bad_d;
  logic                  tready_q;
  logic                  locked_q, locked_d;
  logic                  err_flag_q, err_flag_d;
  logic [CNTR_WIDTH-1:0] err_count_q, err_count_d;
  logic [CNTR_WIDTH-1:0] word_count_q, word_count_d;

  logic beat;
  logic match;
  logic err_inc;
  logic word_inc;

  assign beat  = s_axis_tvalid & tready_q;
  assign match = (s_axis_tdata == pred_q);

  // Sync state machine and prediction.
  always_comb begin
    state_d    = state_q;
    pred_d     = pred_q;
    good_d     = good_q;
    bad_d      = bad_q;
    locked_d   = locked_q;
    err_flag_d = 1'b0;
    err_inc    = 1'b0;
    word_inc   = 1'b0;

    if (beat) begin
      case (state_q)
        StHunt: begin
          pred_d  = lfsr_step(s_axis_tdata);
          good_d  = '0;
          state_d = StSync;
        end

        StSync: begin
          if (match) begin
            pred_d = lfsr_step(pred_q);
            if (good_q == GoodLast) begin
              good_d   = '0;
              bad_d    = '0;
              state_d  = StLock;
              locked_d = 1'b1;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            // Wrong seed: restart from the word just received.
            pred_d = lfsr_step(s_axis_tdata);
            good_d = '0;
          end
        end

        StLock: begin
          word_inc = 1'b1;
          // Free-run so a corrupted word cannot poison later predictions.
          pred_d   = lfsr_step(pred_q);
          if (match) begin
            bad_d = '0;
          end else begin
            err_inc    = 1'b1;
            err_flag_d = 1'b1;
            if (bad_q == BadLast) begin
              bad_d    = '0;
              state_d  = StHunt;
              locked_d = 1'b0;
            end else begin
              bad_d = bad_q + 1'b1;
            end
          end
        end

        default: begin
          state_d  = StHunt;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  // Statistics counters: clear wins over a coincident increment; saturate at all-ones.
  always_comb begin
    err_count_d = err_count_q;
    if (clear) begin
      err_count_d = '0;
    end else if (err_inc && (err_count_q != '1)) begin
      err_count_d = err_count_q + CntOne;
    end
  end

  always_comb begin
    word_count_d = word_count_q;
    if (clear) begin
      word_count_d = '0;
    end else if (word_inc && (word_count_q != '1)) begin
      word_count_d = word_count_q + CntOne;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= StHunt;
      pred_q       <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      tready_q     <= 1'b0;
      locked_q     <= 1'b0;
      err_flag_q   <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pred_q       <= pred_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      tready_q     <= 1'b1;
      locked_q     <= locked_d;
      err_flag_q   <= err_flag_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign locked        = locked_q;
  assign err_flag      = err_flag_q;
  assign err_count     = err_count_q;
  assign word_count    = word_count_q;

endmodule

// File: tb/tb_axis_lfsr_checker.sv
// Bench for axis_lfsr_checker: two instances (32-bit and 4-bit counters) share
// one stimulus stream; a behavioural model predicts every output each cycle.
module tb_axis_lfsr_checker;

  localparam logic [63:0] Seed = 64'h85fac8a1658d6f0d;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        clear = 1'b0;
  logic [63:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b1;

  logic        tready_w, locked_w, flag_w;
  logic [31:0] err_w, word_w;
  logic        tready_n, locked_n, flag_n;
  logic [3:0]  err_n, word_n;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  axis_lfsr_checker #(.CNTR_WIDTH(32), .LOCK_COUNT(16), .LOSS_COUNT(4)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .clear         (clear),
    .s_axis_tready (tready_w),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .locked        (locked_w),
    .err_flag      (flag_w),
    .err_count     (err_w),
    .word_count    (word_w)
  );

  axis_lfsr_checker #(.CNTR_WIDTH(4), .LOCK_COUNT(16), .LOSS_COUNT(4)) dut_narrow (
    .aclk          (aclk),
    .areset        (areset),
    .clear         (clear),
    .s_axis_tready (tready_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .locked        (locked_n),
    .err_flag      (flag_n),
    .err_count     (err_n),
    .word_count    (word_n)
  );

  function automatic logic [63:0] lfsr(input logic [63:0] x);
    return {x[62:0], ~(x[62] ^ x[61])};
  endfunction

  function automatic longint unsigned sat_upd(input longint unsigned v, input bit inc,
                                              input bit clr, input longint unsigned maxv);
    if (clr) return 0;
    if (inc && v < maxv) return v + 1;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 hunting, 1 syncing, 2 locked
  int               m_mode = 0;
  logic [63:0]      m_pred = '0;
  int               m_good = 0;
  int               m_bad = 0;
  bit               m_tready = 0, m_locked = 0, m_flag = 0;
  longint unsigned  m_err_w = 0, m_word_w = 0, m_err_n = 0, m_word_n = 0;
  bit               m_beat, m_inc_e, m_inc_w;

  always @(posedge aclk) begin
    if (areset) begin
      m_mode = 0; m_pred = '0; m_good = 0; m_bad = 0;
      m_tready = 0; m_locked = 0; m_flag = 0;
      m_err_w = 0; m_word_w = 0; m_err_n = 0; m_word_n = 0;
    end else begin
      m_beat = s_axis_tvalid && m_tready;
      m_inc_e = 0;
      m_inc_w = 0;
      m_flag = 0;
      if (m_beat) begin
        if (m_mode == 0) begin
          m_pred = lfsr(s_axis_tdata);
          m_good = 0;
          m_mode = 1;
        end else if (m_mode == 1) begin
          if (s_axis_tdata == m_pred) begin
            m_pred = lfsr(m_pred);
            m_good++;
            if (m_good == 16) begin
              m_mode = 2; m_locked = 1; m_bad = 0;
            end
          end else begin
            m_pred = lfsr(s_axis_tdata);
            m_good = 0;
          end
        end else begin
          m_inc_w = 1;
          if (s_axis_tdata == m_pred) m_bad = 0;
          else begin
            m_inc_e = 1;
            m_flag = 1;
            m_bad++;
            if (m_bad == 4) begin
              m_mode = 0; m_locked = 0;
            end
          end
          m_pred = lfsr(m_pred);
        end
      end
      m_err_w  = sat_upd(m_err_w,  m_inc_e, clear, 64'hffff_ffff);
      m_word_w = sat_upd(m_word_w, m_inc_w, clear, 64'hffff_ffff);
      m_err_n  = sat_upd(m_err_n,  m_inc_e, clear, 64'd15);
      m_word_n = sat_upd(m_word_n, m_inc_w, clear, 64'd15);
      m_tready = 1;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge aclk) begin
    check("tready",      tready_w, m_tready);
    check("locked",      locked_w, m_locked);
    check("err_flag",    flag_w,   m_flag);
    check("err_count",   err_w,    m_err_w);
    check("word_count",  word_w,   m_word_w);
    check("n_tready",    tready_n, m_tready);
    check("n_locked",    locked_n, m_locked);
    check("n_err_flag",  flag_n,   m_flag);
    check("n_err_count", err_n,    m_err_n);
    check("n_word_count", word_n,  m_word_n);
  end

  // ---------------- stimulus ----------------
  logic [63:0] gen;

  task automatic drive(input logic v, input logic [63:0] d, input logic clr);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    clear         = clr;
    @(negedge aclk);
  endtask

  // Send n clean generator beats, with optional idle gaps; optionally pin lock timing.
  task automatic stream(input int n, input int gap_pct, input bit chk_lock);
    int k = 0;
    while (k < n) begin
      if ($urandom_range(99) < gap_pct) begin
        drive(1'b0, {$urandom, $urandom}, 1'b0);
      end else begin
        drive(1'b1, gen, 1'b0);
        gen = lfsr(gen);
        k++;
        if (chk_lock && k == 16) check("lock_not_yet", locked_w, 1'b0);
        if (chk_lock && k == 17) check("lock_at_17", locked_w, 1'b1);
      end
    end
  endtask

  initial begin
    // 1. Reset held 4 cycles with tvalid high.
    areset = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = {$urandom, $urandom};
    repeat (4) @(negedge aclk);
    check("rst_tready", tready_w, 1'b0);
    check("rst_counts", {err_w, word_w}, 64'd0);
    areset = 1'b0;
    drive(1'b0, '0, 1'b0);
    check("tready_after_rst", tready_w, 1'b1);

    // 2. Clean lock, then 100 locked beats.
    gen = Seed;
    check("gen_step", lfsr(gen), 64'h0bf59142cb1ade1b);
    stream(17, 0, 1'b1);
    stream(100, 0, 1'b0);
    check("clean_words", word_w, 32'd100);
    check("clean_errs", err_w, 32'd0);
    check("narrow_word_sat", word_n, 4'd15);

    // 3. Single bit-0 error while locked.
    drive(1'b1, gen ^ 64'h1, 1'b0);
    gen = lfsr(gen);
    check("single_flag", flag_w, 1'b1);
    check("single_err", err_w, 32'd1);
    check("single_locked", locked_w, 1'b1);
    stream(5, 0, 1'b0);
    check("single_err_hold", err_w, 32'd1);
    check("single_words", word_w, 32'd106);

    // 4. Loss of lock after four zero words, then reacquire.
    drive(1'b0, '0, 1'b1);
    check("clear_idle", {err_w, word_w}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h0, 1'b0);
      gen = lfsr(gen);
      if (i == 2) check("loss_still_locked", locked_w, 1'b1);
    end
    check("loss_unlocked", locked_w, 1'b0);
    check("loss_errs", err_w, 32'd4);
    stream(17, 0, 1'b1);
    check("reacq_errs", err_w, 32'd4);

    // 5. Mid-stream reset, then lock through 50% backpressure gaps.
    areset = 1'b1;
    drive(1'b1, {$urandom, $urandom}, 1'b0);
    areset = 1'b0;
    drive(1'b0, '0, 1'b0);
    stream(17, 50, 1'b1);
    stream(30, 50, 1'b0);
    check("gap_words", word_w, 32'd30);
    check("gap_errs", err_w, 32'd0);

    // 6. Saturation of the narrow counter, then clear against an error beat.
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) drive(1'b1, gen ^ {$urandom, $urandom | 32'h1}, 1'b0);
      else drive(1'b1, gen, 1'b0);
      gen = lfsr(gen);
    end
    check("sat_err_narrow", err_n, 4'd15);
    check("sat_locked", locked_n, 1'b1);
    check("sat_err_wide", err_w, 32'd20);
    drive(1'b1, gen ^ 64'h1, 1'b1);
    gen = lfsr(gen);
    check("clr_err_narrow", err_n, 4'd0);
    check("clr_err_wide", err_w, 32'd0);
    check("clr_flag", flag_n, 1'b1);

    // Randomised soak: gaps, corruption bursts of varying density, random clears.
    for (int seg = 0; seg < 8; seg++) begin
      int pct;
      pct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 5 : 70);
      for (int i = 0; i < 50; i++) begin
        logic [63:0] w;
        logic clr;
        clr = ($urandom_range(99) < 3);
        if ($urandom_range(99) < 30) begin
          drive(1'b0, {$urandom, $urandom}, clr);
        end else begin
          w = gen;
          if ($urandom_range(99) < pct) w = gen ^ {$urandom, $urandom | 32'h1};
          drive(1'b1, w, clr);
          gen = lfsr(gen);
        end
      end
    end

    drive(1'b0, '0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
